id_alu_issue: RTL and testbench

ID_ALU_ISSUE -- requirements
Module: id_alu_issue

---
 rtl/id_alu_issue.sv | 175 +++++++++++++++++
 tb/tb_id_alu_issue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_alu_issue.sv
// RV32I integer decode/issue stage: decodes OP, OP-IMM, LUI and AUIPC into ALU operands
// behind a one-entry valid/ready output register. Define ALU_FWD_EN to enable EX-result operand forwarding.

`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef ALU_FN_LEN
`define ALU_FN_LEN 4
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`endif

module id_alu_issue (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [`DWIDTH-1:0]     in_pc,
    input  logic [`DWIDTH-1:0]     rs1_data,
    input  logic [`DWIDTH-1:0]     rs2_data,
    input  logic                   fwd_valid,
    input  logic [4:0]             fwd_rd,
    input  logic [`DWIDTH-1:0]     fwd_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`DWIDTH-1:0]     oper1,
    output logic [`DWIDTH-1:0]     oper2,
    output logic [`ALU_FN_LEN-1:0] alu_fn,
    output logic [4:0]             out_rd,
    output logic                   out_we,
    output logic                   out_illegal
);
    localparam int DW = `DWIDTH;
    localparam int FNL = `ALU_FN_LEN;

    logic           valid_q;
    logic [DW-1:0]  oper1_q, oper1_d;
    logic [DW-1:0]  oper2_q, oper2_d;
    logic [FNL-1:0] fn_q, fn_d;
    logic [4:0]     rd_q;
    logic           we_q, we_d;
    logic           ill_q;
    logic           legal_d;
    logic           accept;
    logic [DW-1:0]  rs1_val, rs2_val;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd_idx;
    logic [DW-1:0] imm_i, imm_u;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rd_idx = in_inst[11:7];
    assign imm_i  = DW'($signed(in_inst[31:20]));
    assign imm_u  = DW'($signed({in_inst[31:12], 12'b0}));

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef ALU_FWD_EN
    assign rs1_val = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_inst[19:15]) ? fwd_data : rs1_data;
    assign rs2_val = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_inst[24:20]) ? fwd_data : rs2_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
    assign rs1_val = rs1_data;
    assign rs2_val = rs2_data;
`endif

    // funct3 -> ALU op; alt selects SUB/SRA where funct3 has a second form.
    function automatic logic [FNL-1:0] f3_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_fn = alt ? `ALU_SUB : `ALU_ADD;
            3'b001:  f3_fn = `ALU_SLL;
            3'b010:  f3_fn = `ALU_SLT;
            3'b011:  f3_fn = `ALU_SLTU;
            3'b100:  f3_fn = `ALU_XOR;
            3'b101:  f3_fn = alt ? `ALU_SRA : `ALU_SRL;
            3'b110:  f3_fn = `ALU_OR;
            default: f3_fn = `ALU_AND;
        endcase
    endfunction

    always_comb begin
        oper1_d = '0;
        oper2_d = '0;
        fn_d    = `ALU_ADD;
        legal_d = 1'b0;
        case (opcode)
            7'b0110011: begin
                oper1_d = rs1_val;
                oper2_d = rs2_val;
                fn_d    = f3_fn(funct3, funct7 == 7'b0100000);
                if (funct3 == 3'b000 || funct3 == 3'b101)
                    legal_d = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else
                    legal_d = (funct7 == 7'b0000000);
            end
            7'b0010011: begin
                oper1_d = rs1_val;
                oper2_d = imm_i;
                fn_d    = f3_fn(funct3, (funct3 == 3'b101) && (funct7 == 7'b0100000));
                if (funct3 == 3'b001)
                    legal_d = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    legal_d = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else
                    legal_d = 1'b1;
            end
            7'b0110111: begin
                oper2_d = imm_u;
                legal_d = 1'b1;
            end
            7'b0010111: begin
                oper1_d = in_pc;
                oper2_d = imm_u;
                legal_d = 1'b1;
            end
            default: legal_d = 1'b0;
        endcase
        // Illegal entries still flow downstream, but as an inert ADD 0,0 with no writeback.
        if (!legal_d) begin
            oper1_d = '0;
            oper2_d = '0;
            fn_d    = `ALU_ADD;
        end
        we_d = legal_d && (rd_idx != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            oper1_q <= '0;
            oper2_q <= '0;
            fn_q    <= `ALU_ADD;
            rd_q    <= '0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            oper1_q <= oper1_d;
            oper2_q <= oper2_d;
            fn_q    <= fn_d;
            rd_q    <= rd_idx;
            we_q    <= we_d;
            ill_q   <= !legal_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign oper1       = oper1_q;
    assign oper2       = oper2_q;
    assign alu_fn      = fn_q;
    assign out_rd      = rd_q;
    assign out_we      = we_q;
    assign out_illegal = ill_q;
endmodule

// File: tb/tb_id_alu_issue.sv
// Directed bench for id_alu_issue: decode vector table plus stall, flush, reset and forwarding sequences.

module tb_id_alu_issue;
    localparam logic [3:0] FN_ADD = 4'd0, FN_SUB = 4'd1, FN_SLL = 4'd2, FN_SLT = 4'd3,
                           FN_SLTU = 4'd4, FN_XOR = 4'd5, FN_SRL = 4'd6, FN_SRA = 4'd7,
                           FN_OR = 4'd8, FN_AND = 4'd9;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, rs1_data, rs2_data, fwd_data, oper1, oper2;
    logic        fwd_valid, out_we, out_illegal;
    logic [4:0]  fwd_rd, out_rd;
    logic [3:0]  alu_fn;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    id_alu_issue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .oper1(oper1), .oper2(oper2),
        .alu_fn(alu_fn), .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [3:0]  efn;
        logic [4:0]  erd;
        logic        ewe;
        logic        eill;
    } vec_t;

    vec_t vecs[19];

    task automatic check_out(input string nm, input logic ev, input logic [31:0] e1, input logic [31:0] e2,
                             input logic [3:0] efn, input logic [4:0] erd, input logic ewe, input logic eill);
        total++;
        if ({out_valid, oper1, oper2, alu_fn, out_rd, out_we, out_illegal} !== {ev, e1, e2, efn, erd, ewe, eill}) begin
            bad++;
            $display("FAIL %s: got v=%0b o1=%h o2=%h fn=%0d rd=%0d we=%0b ill=%0b, want v=%0b o1=%h o2=%h fn=%0d rd=%0d we=%0b ill=%0b",
                     nm, out_valid, oper1, oper2, alu_fn, out_rd, out_we, out_illegal, ev, e1, e2, efn, erd, ewe, eill);
        end else begin
            $display("ok   %s: v=%0b o1=%h o2=%h fn=%0d rd=%0d we=%0b ill=%0b",
                     nm, out_valid, oper1, oper2, alu_fn, out_rd, out_we, out_illegal);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", nm, got, want);
        end else begin
            $display("ok   %s: %0b", nm, got);
        end
    endtask

    task automatic apply(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
        in_inst  = inst;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{"add",       32'h002081B3, 32'h0,   32'h5,    32'h7,  32'h5,    32'h7,        FN_ADD,  5'd3,  1'b1, 1'b0};
        vecs[1]  = '{"sub",       32'h407302B3, 32'h0,   32'hA,    32'h3,  32'hA,    32'h3,        FN_SUB,  5'd5,  1'b1, 1'b0};
        vecs[2]  = '{"addi_m1",   32'hFFF00093, 32'h0,   32'h0,    32'h99, 32'h0,    32'hFFFFFFFF, FN_ADD,  5'd1,  1'b1, 1'b0};
        vecs[3]  = '{"srai",      32'h4032D293, 32'h0,   32'h80,   32'h0,  32'h80,   32'h403,      FN_SRA,  5'd5,  1'b1, 1'b0};
        vecs[4]  = '{"slli_bad",  32'h02109113, 32'h0,   32'h11,   32'h22, 32'h0,    32'h0,        FN_ADD,  5'd2,  1'b0, 1'b1};
        vecs[5]  = '{"auipc",     32'h12345217, 32'h100, 32'h11,   32'h22, 32'h100,  32'h12345000, FN_ADD,  5'd4,  1'b1, 1'b0};
        vecs[6]  = '{"lui_x0",    32'h00001037, 32'h0,   32'h55,   32'h66, 32'h0,    32'h1000,     FN_ADD,  5'd0,  1'b0, 1'b0};
        vecs[7]  = '{"xor",       32'h009443B3, 32'h0,   32'hF0,   32'h0F, 32'hF0,   32'h0F,       FN_XOR,  5'd7,  1'b1, 1'b0};
        vecs[8]  = '{"sltu",      32'h00C5B533, 32'h0,   32'h1,    32'h2,  32'h1,    32'h2,        FN_SLTU, 5'd10, 1'b1, 1'b0};
        vecs[9]  = '{"op_f7_bad", 32'h022081B3, 32'h0,   32'h5,    32'h7,  32'h0,    32'h0,        FN_ADD,  5'd3,  1'b0, 1'b1};
        vecs[10] = '{"load_bad",  32'h0000A103, 32'h0,   32'h1,    32'h2,  32'h0,    32'h0,        FN_ADD,  5'd2,  1'b0, 1'b1};
        vecs[11] = '{"andi",      32'h7FF37313, 32'h0,   32'h1234, 32'h0,  32'h1234, 32'h7FF,      FN_AND,  5'd6,  1'b1, 1'b0};
        vecs[12] = '{"slti_neg",  32'h80012093, 32'h0,   32'h3,    32'h0,  32'h3,    32'hFFFFF800, FN_SLT,  5'd1,  1'b1, 1'b0};
        vecs[13] = '{"srl",       32'h003150B3, 32'h0,   32'h100,  32'h4,  32'h100,  32'h4,        FN_SRL,  5'd1,  1'b1, 1'b0};
        vecs[14] = '{"srli_bad",  32'h42015093, 32'h0,   32'h100,  32'h4,  32'h0,    32'h0,        FN_ADD,  5'd1,  1'b0, 1'b1};
        vecs[15] = '{"add_x0",    32'h00208033, 32'h0,   32'h8,    32'h9,  32'h8,    32'h9,        FN_ADD,  5'd0,  1'b0, 1'b0};
        vecs[16] = '{"sra",       32'h403150B3, 32'h0,   32'h100,  32'h4,  32'h100,  32'h4,        FN_SRA,  5'd1,  1'b1, 1'b0};
        vecs[17] = '{"slli",      32'h00509113, 32'h0,   32'h7,    32'h0,  32'h7,    32'h5,        FN_SLL,  5'd2,  1'b1, 1'b0};
        vecs[18] = '{"or",        32'h003160B3, 32'h0,   32'hA0,   32'h0B, 32'hA0,   32'h0B,       FN_OR,   5'd1,  1'b1, 1'b0};

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'h0;
        apply(32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 check_out("reset_state", 1'b0, 32'h0, 32'h0, FN_ADD, 5'd0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b0;

        // Back-to-back stream: every vector accepted on consecutive edges.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            apply(vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            in_valid = 1'b1;
            #1 check_bit({vecs[i].name, "_in_ready"}, in_ready, 1'b1);
            @(posedge clk);
            #1 check_out(vecs[i].name, 1'b1, vecs[i].e1, vecs[i].e2, vecs[i].efn, vecs[i].erd, vecs[i].ewe, vecs[i].eill);
        end

        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);
        #1 check_bit("drain_valid", out_valid, 1'b0);

        // Stall: entry A held for 3 cycles while B waits upstream.
        @(negedge clk);
        apply(vecs[0].inst, 32'h0, 32'h5, 32'h7);
        in_valid = 1'b1;
        @(posedge clk);
        #1 check_out("stall_load_a", 1'b1, 32'h5, 32'h7, FN_ADD, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        apply(vecs[1].inst, 32'h0, 32'hA, 32'h3);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check_bit("stall_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1 check_out("stall_hold_a", 1'b1, 32'h5, 32'h7, FN_ADD, 5'd3, 1'b1, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check_bit("unstall_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 check_out("unstall_load_b", 1'b1, 32'hA, 32'h3, FN_SUB, 5'd5, 1'b1, 1'b0);

        // Flush coincident with an accept while out_valid=1.
        @(negedge clk);
        apply(vecs[7].inst, 32'h0, 32'hF0, 32'h0F);
        flush = 1'b1;
        #1 check_bit("flush_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 check_bit("flush_valid", out_valid, 1'b0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1 check_bit("post_flush_valid", out_valid, 1'b0);

        // Flush while stalled.
        @(negedge clk);
        apply(vecs[8].inst, 32'h0, 32'h1, 32'h2);
        in_valid = 1'b1;
        @(posedge clk);
        #1 check_out("fstall_load", 1'b1, 32'h1, 32'h2, FN_SLTU, 5'd10, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        @(posedge clk);
        #1 check_bit("fstall_valid", out_valid, 1'b0);

        // Reset mid-stall, then reset overriding an accept and a flush.
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        apply(vecs[5].inst, 32'h100, 32'h0, 32'h0);
        @(posedge clk);
        #1 check_out("rstall_load", 1'b1, 32'h100, 32'h12345000, FN_ADD, 5'd4, 1'b1, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        apply(vecs[11].inst, 32'h0, 32'h1234, 32'h0);
        @(posedge clk);
        #1 check_out("rstall_hold", 1'b1, 32'h100, 32'h12345000, FN_ADD, 5'd4, 1'b1, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 check_out("rstall_reset", 1'b0, 32'h0, 32'h0, FN_ADD, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 check_out("reset_over_accept", 1'b0, 32'h0, 32'h0, FN_ADD, 5'd0, 1'b0, 1'b0);

        // Forwarding behaviour on ADD x3,x1,x1 and ADD x3,x1,x2 with zero register data.
        @(negedge clk);
        reset = 1'b0; flush = 1'b0;
        apply(32'h001081B3, 32'h0, 32'h0, 32'h0);
        fwd_valid = 1'b1; fwd_rd = 5'd1; fwd_data = 32'hAA;
        @(posedge clk);
`ifdef ALU_FWD_EN
        #1 check_out("fwd_x1_both", 1'b1, 32'hAA, 32'hAA, FN_ADD, 5'd3, 1'b1, 1'b0);
`else
        #1 check_out("fwd_ignored", 1'b1, 32'h0, 32'h0, FN_ADD, 5'd3, 1'b1, 1'b0);
`endif
        @(negedge clk) fwd_rd = 5'd0;
        @(posedge clk);
        #1 check_out("fwd_rd0", 1'b1, 32'h0, 32'h0, FN_ADD, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        apply(32'h002081B3, 32'h0, 32'h0, 32'h0);
        fwd_rd = 5'd2;
        @(posedge clk);
`ifdef ALU_FWD_EN
        #1 check_out("fwd_x2_rs2", 1'b1, 32'h0, 32'hAA, FN_ADD, 5'd3, 1'b1, 1'b0);
`else
        #1 check_out("fwd_x2_ignored", 1'b1, 32'h0, 32'h0, FN_ADD, 5'd3, 1'b1, 1'b0);
`endif
        @(negedge clk);
        in_valid = 1'b0; fwd_valid = 1'b0;
        @(posedge clk);
        #1 check_bit("final_drain", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
